// File: rtl/wb_regfile_pkg.sv
// Shared widths and host FSM state encodings for the WB-stage register file.
package wb_regfile_pkg;
  localparam int WB_DATA_W = 64;
  localparam int WB_ADDR_W = 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;
endpackage

// File: rtl/wb_host_fsm.sv
// Four-phase host req/ack sequencer for register file debug/load access.
// Latency: ack two edges after req is first sampled when not blocked.
// Backpressure: a host write waits in ACCESS while the pipeline is writing.
module wb_host_fsm
  import wb_regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic host_req,
  input  logic host_we,
  input  logic pipe_we,
  output logic host_wr_en,
  output logic host_rd_latch,
  output logic host_ack
);

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic [7:0] r_wait_cnt;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (host_req) w_next = S_ACCESS;
      S_ACCESS: if (!host_we || !pipe_we) w_next = S_ACK;
      S_ACK:    if (!host_req) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && host_req)
        r_wait_cnt <= 8'd0;
      else if (r_state == S_ACCESS && host_we && pipe_we && r_wait_cnt != 8'hFF)
        r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Pipeline writes own the single write port; host writes only slip in when it is idle.
  assign host_wr_en    = (r_state == S_ACCESS) && host_we && !pipe_we;
  assign host_rd_latch = (r_state == S_ACCESS) && !host_we;
  assign host_ack      = (r_state == S_ACK);

  a_access_exit: assert property (@(posedge clk) disable iff (!reset)
    (r_state == S_ACCESS && !pipe_we) |=> (r_state == S_ACK));

  a_wait_count: assert property (@(posedge clk) disable iff (!reset)
    (r_state == S_ACCESS && host_we && pipe_we)
      |=> (r_wait_cnt == 8'hFF || r_wait_cnt == $past(r_wait_cnt) + 8'd1));

endmodule

// File: rtl/wb_regfile.sv
// Register file after MEM/WB: one pipeline write port, two bypassed read ports, host port.
// Latency: reads combinational; host access acks two edges after req when not blocked.
// Backpressure: host writes stall while WRegEn_in is high; pipeline is never stalled.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATAPATH_WIDTH = WB_DATA_W,
  parameter int REGFILE_ADDR   = WB_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      WRegEn_in,
  input  logic [REGFILE_ADDR-1:0]   WReg1_in,
  input  logic [DATAPATH_WIDTH-1:0] WData_in,
  input  logic [REGFILE_ADDR-1:0]   RReg1,
  input  logic [REGFILE_ADDR-1:0]   RReg2,
  output logic [DATAPATH_WIDTH-1:0] RData1,
  output logic [DATAPATH_WIDTH-1:0] RData2,
  input  logic                      host_req,
  input  logic                      host_we,
  input  logic [REGFILE_ADDR-1:0]   host_addr,
  input  logic [DATAPATH_WIDTH-1:0] host_wdata,
  output logic                      host_ack,
  output logic [DATAPATH_WIDTH-1:0] host_rdata
);

  localparam int DEPTH = 2 ** REGFILE_ADDR;

  logic [DATAPATH_WIDTH-1:0] r_regs [DEPTH];
  logic [DATAPATH_WIDTH-1:0] r_host_rdata;

  logic                      w_host_wr_en;
  logic                      w_host_rd_latch;
  logic                      w_we;
  logic [REGFILE_ADDR-1:0]   w_waddr;
  logic [DATAPATH_WIDTH-1:0] w_wdata;
  logic [DATAPATH_WIDTH-1:0] w_host_rd;

  wb_host_fsm u_host_fsm (
    .clk           (clk),
    .reset         (reset),
    .host_req      (host_req),
    .host_we       (host_we),
    .pipe_we       (WRegEn_in),
    .host_wr_en    (w_host_wr_en),
    .host_rd_latch (w_host_rd_latch),
    .host_ack      (host_ack)
  );

  assign w_we    = WRegEn_in | w_host_wr_en;
  assign w_waddr = WRegEn_in ? WReg1_in : host_addr;
  assign w_wdata = WRegEn_in ? WData_in : host_wdata;

  assign RData1    = (WRegEn_in && WReg1_in == RReg1)     ? WData_in : r_regs[RReg1];
  assign RData2    = (WRegEn_in && WReg1_in == RReg2)     ? WData_in : r_regs[RReg2];
  assign w_host_rd = (WRegEn_in && WReg1_in == host_addr) ? WData_in : r_regs[host_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_host_rdata <= '0;
    end else begin
      if (w_we) r_regs[w_waddr] <= w_wdata;
      if (w_host_rd_latch) r_host_rdata <= w_host_rd;
    end
  end

  assign host_rdata = r_host_rdata;

endmodule
